// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - issue gate between decode and functional units: RAW/WAW hazards and unit occupancy
module issue_scoreboard #(
   parameter int MUL_DEPTH   = 2,
   parameter int DIV_DEPTH   = 1,
   parameter int LSU_DEPTH   = 1,
   parameter int ARITH_DEPTH = 1
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dec_valid,
   input  logic [4:0]  dec_rs1,
   input  logic [4:0]  dec_rs2,
   input  logic [4:0]  dec_rd,
   input  logic        dec_wen,
   input  logic [1:0]  dec_fu,
   input  logic        flush,
   input  logic [3:0]  wb_valid,
   input  logic [19:0] wb_rd,
   output logic        issue_ready,
   output logic        issue_fire,
   output logic [31:0] busy_regs,
   output logic [1:0]  stall_cause,
   output logic        sb_err
);

   // Unit codes double as indices into wb_valid / wb_rd and the per-unit counters.
   localparam logic [1:0] FU_ARITH = 2'd0;
   localparam logic [1:0] FU_MUL   = 2'd1;
   localparam logic [1:0] FU_DIV   = 2'd2;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_RAW  = 2'd1;
   localparam logic [1:0] CAUSE_WAW  = 2'd2;
   localparam logic [1:0] CAUSE_FULL = 2'd3;

   function automatic int unit_depth(input logic [1:0] fu);
      case (fu)
         FU_ARITH: return ARITH_DEPTH;
         FU_MUL:   return MUL_DEPTH;
         FU_DIV:   return DIV_DEPTH;
         default:  return LSU_DEPTH;
      endcase
   endfunction

   logic [31:0] wb_clr_mask;
   logic [31:0] eff_busy;
   logic [31:0] issue_set_mask;
   logic [3:0]  unit_full;
   logic [3:0]  unit_underflow;
   logic        raw_hazard;
   logic        waw_hazard;
   logic        fu_full;

   // Registers released by this cycle's writebacks; x0 is never tracked.
   always_comb begin
      wb_clr_mask = '0;
      for (int u = 0; u < 4; u++) begin
         if (wb_valid[u]) begin
            wb_clr_mask[wb_rd[5*u +: 5]] = 1'b1;
         end
      end
      wb_clr_mask[0] = 1'b0;
   end

   // Same-cycle writeback bypass: a completing register no longer blocks a dependent.
   assign eff_busy = busy_regs & ~wb_clr_mask;

   assign raw_hazard = ((dec_rs1 != 5'd0) && eff_busy[dec_rs1]) ||
                       ((dec_rs2 != 5'd0) && eff_busy[dec_rs2]);
   assign waw_hazard = dec_wen && (dec_rd != 5'd0) && eff_busy[dec_rd];
   assign fu_full    = unit_full[dec_fu];

   assign issue_ready = ~flush & ~raw_hazard & ~waw_hazard & ~fu_full;
   assign issue_fire  = dec_valid & issue_ready;

   // Report the highest-priority reason the presented instruction is held back.
   always_comb begin
      stall_cause = CAUSE_NONE;
      if (dec_valid) begin
         if (raw_hazard) begin
            stall_cause = CAUSE_RAW;
         end else if (waw_hazard) begin
            stall_cause = CAUSE_WAW;
         end else if (fu_full) begin
            stall_cause = CAUSE_FULL;
         end
      end
   end

   // Destination claimed by the instruction issuing this cycle.
   always_comb begin
      issue_set_mask = '0;
      if (issue_fire && dec_wen && (dec_rd != 5'd0)) begin
         issue_set_mask[dec_rd] = 1'b1;
      end
   end

   // Busy vector: clears first, then the new claim, so a simultaneous set wins.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         busy_regs <= '0;
      end else begin
         busy_regs <= ((busy_regs & ~wb_clr_mask) | issue_set_mask) & 32'hFFFF_FFFE;
      end
   end

   // Per-unit in-flight counters sized to exactly hold their depth.
   for (genvar u = 0; u < 4; u++) begin : g_unit
      localparam int DEPTH = unit_depth(2'(u));
      localparam int CW    = $clog2(DEPTH + 1);

      logic [CW-1:0] count;
      logic          inc;
      logic          dec;

      assign inc               = issue_fire && (dec_fu == 2'(u));
      assign dec               = wb_valid[u] && (count != '0);
      assign unit_underflow[u] = wb_valid[u] && (count == '0);
      assign unit_full[u]      = ((count - CW'(dec)) == CW'(DEPTH));

      // Issue and completion in the same cycle cancel; a spurious completion at zero is ignored.
      always_ff @(posedge CLK or negedge nRST) begin
         if (!nRST) begin
            count <= '0;
         end else if (inc && !dec) begin
            count <= count + CW'(1);
         end else if (dec && !inc) begin
            count <= count - CW'(1);
         end
      end
   end

   // Sticky flag for a completion arriving on a unit with nothing in flight.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         sb_err <= 1'b0;
      end else if (|unit_underflow) begin
         sb_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - scoreboard bench for issue_scoreboard against a queue-based reference model
module tb_issue_scoreboard;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic        dec_valid = 1'b0;
   logic [4:0]  dec_rs1 = '0;
   logic [4:0]  dec_rs2 = '0;
   logic [4:0]  dec_rd = '0;
   logic        dec_wen = 1'b0;
   logic [1:0]  dec_fu = '0;
   logic        flush = 1'b0;
   logic [3:0]  wb_valid = '0;
   logic [19:0] wb_rd = '0;
   logic        issue_ready;
   logic        issue_fire;
   logic [31:0] busy_regs;
   logic [1:0]  stall_cause;
   logic        sb_err;

   issue_scoreboard #(
      .MUL_DEPTH(2), .DIV_DEPTH(1), .LSU_DEPTH(1), .ARITH_DEPTH(1)
   ) dut (
      .CLK(CLK), .nRST(nRST),
      .dec_valid(dec_valid), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .dec_wen(dec_wen), .dec_fu(dec_fu), .flush(flush),
      .wb_valid(wb_valid), .wb_rd(wb_rd),
      .issue_ready(issue_ready), .issue_fire(issue_fire), .busy_regs(busy_regs),
      .stall_cause(stall_cause), .sb_err(sb_err)
   );

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      logic        ready;
      logic        fire;
      logic [1:0]  cause;
      logic [31:0] busy;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model: set of busy registers, list of in-flight destinations per unit.
   bit [31:0] m_busy = '0;
   int        uq[4][$];
   bit        m_err = 1'b0;

   function automatic int depth_of(input int u);
      case (u)
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic logic [19:0] wbr(input int u, input int rd);
      logic [19:0] r;
      r = '0;
      r[5*u +: 5] = 5'(rd);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = '0;
      m_err = 1'b0;
      for (int u = 0; u < 4; u++) uq[u].delete();
   endtask

   task automatic drive_cycle(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic wen, input logic [1:0] fu,
                              input logic fl, input logic [3:0] wbv, input logic [19:0] wbrd);
      bit [31:0] eff;
      bit        raw, waw, full, rdy, fire;
      int        cnt;
      logic [1:0] cause;
      exp_t      e;
      @(negedge CLK);
      #1;
      dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd;
      dec_wen = wen; dec_fu = fu; flush = fl; wb_valid = wbv; wb_rd = wbrd;
      eff = m_busy;
      for (int u = 0; u < 4; u++)
         if (wbv[u] && wbrd[5*u +: 5] != 5'd0) eff[wbrd[5*u +: 5]] = 1'b0;
      raw = (rs1 != 0 && eff[rs1]) || (rs2 != 0 && eff[rs2]);
      waw = wen && rd != 0 && eff[rd];
      cnt = uq[fu].size();
      if (wbv[fu] && cnt > 0) cnt--;
      full = (cnt == depth_of(int'(fu)));
      rdy = !fl && !raw && !waw && !full;
      fire = v && rdy;
      cause = !v ? 2'd0 : raw ? 2'd1 : waw ? 2'd2 : full ? 2'd3 : 2'd0;
      e = '{rdy, fire, cause, m_busy, m_err};
      exp_q.push_back(e);
      for (int u = 0; u < 4; u++) begin
         if (wbv[u]) begin
            if (wbrd[5*u +: 5] != 5'd0) m_busy[wbrd[5*u +: 5]] = 1'b0;
            if (uq[u].size() > 0) void'(uq[u].pop_front());
            else m_err = 1'b1;
         end
      end
      if (fire) begin
         uq[fu].push_back(wen ? int'(rd) : 0);
         if (wen && rd != 0) m_busy[rd] = 1'b1;
      end
   endtask

   task automatic idle();
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 4'b0, 20'b0);
   endtask

   task automatic rand_cycle();
      logic [3:0]  wbv;
      logic [19:0] wbrd;
      wbv = '0;
      wbrd = '0;
      for (int u = 0; u < 4; u++) begin
         if (uq[u].size() > 0 && $urandom_range(1, 0) == 1) begin
            wbv[u] = 1'b1;
            wbrd[5*u +: 5] = 5'(uq[u][0]);
         end
      end
      drive_cycle($urandom_range(9, 0) < 8, 5'($urandom_range(11, 0)), 5'($urandom_range(11, 0)),
                  5'($urandom_range(11, 0)), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                  $urandom_range(15, 0) == 0, wbv, wbrd);
   endtask

   task automatic drain();
      logic [3:0]  wbv;
      logic [19:0] wbrd;
      for (int k = 0; k < 10; k++) begin
         if (uq[0].size() == 0 && uq[1].size() == 0 && uq[2].size() == 0 && uq[3].size() == 0) break;
         wbv = '0;
         wbrd = '0;
         for (int u = 0; u < 4; u++) begin
            if (uq[u].size() > 0) begin
               wbv[u] = 1'b1;
               wbrd[5*u +: 5] = 5'(uq[u][0]);
            end
         end
         drive_cycle(0, 0, 0, 0, 0, 0, 0, wbv, wbrd);
      end
      idle();
   endtask

   // Monitor: pops the expectation of each driven cycle and compares away from the edge.
   initial begin
      forever begin
         @(negedge CLK);
         #3;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("mon_ready", issue_ready, mon_e.ready);
            chk("mon_fire", issue_fire, mon_e.fire);
            chk("mon_cause", stall_cause, mon_e.cause);
            chk("mon_busy", busy_regs, mon_e.busy);
            chk("mon_err", sb_err, mon_e.err);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      chk("rst_busy", busy_regs, 0);
      chk("rst_err", sb_err, 0);
      chk("rst_ready", issue_ready, 1);
      chk("rst_fire", issue_fire, 0);
      chk("rst_cause", stall_cause, 0);
      #1 nRST = 1'b1;

      // Plain issue, then destination becomes busy.
      drive_cycle(1, 3, 4, 5, 1, 0, 0, 4'b0, 20'b0);
      #2 chk("t1_fire", issue_fire, 1);
      idle();
      #2 chk("t1_busy", busy_regs, 32'h20);

      // RAW stall, then bypass on the writeback cycle.
      drive_cycle(1, 5, 0, 0, 0, 0, 0, 4'b0, 20'b0);
      #2 chk("t2_ready", issue_ready, 0);
      chk("t2_cause", stall_cause, 1);
      drive_cycle(1, 5, 0, 0, 0, 0, 0, 4'b0001, wbr(0, 5));
      #2 chk("t2_bypass_fire", issue_fire, 1);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 4'b0001, 20'b0);

      // Multiplier fills, third issues as first completes.
      drive_cycle(1, 0, 0, 6, 1, 1, 0, 4'b0, 20'b0);
      drive_cycle(1, 0, 0, 7, 1, 1, 0, 4'b0, 20'b0);
      drive_cycle(1, 0, 0, 8, 1, 1, 0, 4'b0, 20'b0);
      #2 chk("t3_cause_full", stall_cause, 3);
      drive_cycle(1, 0, 0, 8, 1, 1, 0, 4'b0010, wbr(1, 6));
      #2 chk("t3_fire", issue_fire, 1);
      idle();
      #2 chk("t3_busy", busy_regs, 32'h180);

      // WAW stall against a divide, set wins on the writeback cycle.
      drive_cycle(1, 0, 0, 9, 1, 2, 0, 4'b0, 20'b0);
      drive_cycle(1, 0, 0, 9, 1, 0, 0, 4'b0, 20'b0);
      #2 chk("t4_cause_waw", stall_cause, 2);
      drive_cycle(1, 0, 0, 9, 1, 0, 0, 4'b0100, wbr(2, 9));
      #2 chk("t4_fire", issue_fire, 1);
      idle();
      #2 chk("t4_busy9", busy_regs[9], 1);

      // Flush blocks a clean instruction; spurious divide completion is sticky.
      drive_cycle(1, 1, 2, 10, 1, 3, 1, 4'b0, 20'b0);
      #2 chk("t5_flush_fire", issue_fire, 0);
      chk("t5_flush_cause", stall_cause, 0);
      idle();
      #2 chk("t5_busy_kept", busy_regs, 32'h380);
      drive_cycle(0, 0, 0, 0, 0, 0, 0, 4'b0100, 20'b0);
      idle();
      #2 chk("t5_err", sb_err, 1);

      repeat (300) rand_cycle();
      drain();

      // Asynchronous reset mid-cycle with state outstanding.
      drive_cycle(1, 0, 0, 12, 1, 2, 0, 4'b0, 20'b0);
      drive_cycle(1, 0, 0, 13, 1, 1, 0, 4'b0, 20'b0);
      @(posedge CLK);
      #2 chk("pre_rst_busy", busy_regs, 32'h3000);
      chk("pre_rst_err", sb_err, 1);
      nRST = 1'b0;
      dec_valid = 1'b0; wb_valid = '0; flush = 1'b0;
      #1 chk("arst_busy", busy_regs, 0);
      chk("arst_err", sb_err, 0);
      chk("arst_ready", issue_ready, 1);
      chk("arst_cause", stall_cause, 0);
      model_reset();
      #1 nRST = 1'b1;
      drive_cycle(1, 0, 0, 12, 1, 2, 0, 4'b0, 20'b0);
      #2 chk("post_rst_div_fire", issue_fire, 1);

      repeat (200) rand_cycle();
      drain();
      #5 chk("queue_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
